bcp_assign_trail: RTL and testbench

- Downstream/control stage of the hardware BCP check unit.
- Owns the live assignment and free vectors that feed the checker.
- Accepts decisions from the search controller, issues check requests, and consumes conflict/implication results.
- Records every assignment on a LIFO trail tagged with decision level, and performs chronological backtrack one trail entry per cycle.

---
 rtl/bcp_assign_trail.sv | 200 ++++++++++++++++++++
 tb/tb_bcp_assign_trail.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcp_assign_trail.sv
// bcp_assign_trail: assignment/free vector owner and LIFO trail for the BCP check unit.
// Accepts decisions, drives check requests, absorbs implication/conflict results,
// and performs chronological backtrack one trail entry per cycle.
// Optional macro BCP_TRAIL_STATS_EN adds saturating conflict/implication counters;
// when undefined the stat ports are tied to zero.
module bcp_assign_trail #(
  parameter int unsigned VAR_NUM = 8,
  parameter int unsigned VIDX_W  = $clog2(VAR_NUM),
  parameter int unsigned LVL_W   = $clog2(VAR_NUM + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic [VIDX_W-1:0]  dec_var,
  input  logic               dec_val,
  input  logic               bt_valid,
  input  logic [LVL_W-1:0]   bt_level,
  output logic               chk_request,
  input  logic               chk_done,
  input  logic               chk_conflict,
  input  logic               chk_imp_valid,
  input  logic [VIDX_W-1:0]  chk_imp_var,
  input  logic               chk_imp_val,
  output logic [VAR_NUM-1:0] free,
  output logic [VAR_NUM-1:0] assignment,
  output logic [LVL_W-1:0]   level,
  output logic [LVL_W-1:0]   trail_count,
  output logic               conflict,
  output logic               all_assigned,
  output logic               dec_err,
  output logic [15:0]        stat_conflicts,
  output logic [15:0]        stat_imps
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_CONFLICT = 3'd3;
  localparam logic [2:0] S_BT       = 3'd4;

  logic [2:0]        state, state_next;
  logic [VIDX_W-1:0] trail_var [VAR_NUM];
  logic [LVL_W-1:0]  trail_lvl [VAR_NUM];
  logic [LVL_W-1:0]  bt_target;

  logic [VIDX_W-1:0] push_idx, top_idx, top_var;
  logic [LVL_W-1:0]  top_lvl;

  logic              push_en, pop_en, lvl_inc, set_conflict;
  logic              bt_latch, bt_finish, dec_drop;
  logic [VIDX_W-1:0] push_var;
  logic              push_val;
  logic [LVL_W-1:0]  push_lvl;

  // Trail top/next-free addressing; top is only consulted while trail_count > 0
  assign push_idx = VIDX_W'(trail_count);
  assign top_idx  = VIDX_W'(trail_count - LVL_W'(1));
  assign top_var  = trail_var[top_idx];
  assign top_lvl  = trail_lvl[top_idx];

  assign all_assigned = (free == '0) && !conflict;
  assign dec_ready    = (state == S_IDLE) && !bt_valid && !all_assigned;

  // Next-state and datapath control decode
  always_comb begin
    state_next   = state;
    push_en      = 1'b0;
    push_var     = dec_var;
    push_val     = dec_val;
    push_lvl     = level;
    pop_en       = 1'b0;
    lvl_inc      = 1'b0;
    set_conflict = 1'b0;
    bt_latch     = 1'b0;
    bt_finish    = 1'b0;
    dec_drop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bt_valid) begin
          bt_latch   = 1'b1;
          state_next = S_BT;
        end else if (dec_valid && dec_ready) begin
          if (free[dec_var]) begin
            push_en    = 1'b1;
            push_lvl   = LVL_W'(level + LVL_W'(1));
            lvl_inc    = 1'b1;
            state_next = S_REQ;
          end else begin
            dec_drop = 1'b1;
          end
        end
      end
      S_REQ: state_next = S_WAIT;
      S_WAIT: begin
        if (chk_done) begin
          if (chk_conflict) begin
            set_conflict = 1'b1;
            state_next   = S_CONFLICT;
          end else if (chk_imp_valid) begin
            if (free[chk_imp_var]) begin
              push_en    = 1'b1;
              push_var   = chk_imp_var;
              push_val   = chk_imp_val;
              state_next = S_REQ;
            end else if (assignment[chk_imp_var] == chk_imp_val) begin
              state_next = S_IDLE;
            end else begin
              set_conflict = 1'b1;
              state_next   = S_CONFLICT;
            end
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_CONFLICT: begin
        if (bt_valid) begin
          bt_latch   = 1'b1;
          state_next = S_BT;
        end
      end
      S_BT: begin
        if ((trail_count != '0) && (top_lvl > bt_target)) begin
          pop_en = 1'b1;
        end else begin
          bt_finish  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, vectors, level/count and handshake pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      free        <= '1;
      assignment  <= '0;
      level       <= '0;
      trail_count <= '0;
      conflict    <= 1'b0;
      chk_request <= 1'b0;
      dec_err     <= 1'b0;
      bt_target   <= '0;
    end else begin
      state       <= state_next;
      chk_request <= (state_next == S_REQ);
      dec_err     <= dec_drop;
      if (push_en) begin
        free[push_var]       <= 1'b0;
        assignment[push_var] <= push_val;
        trail_count          <= LVL_W'(trail_count + LVL_W'(1));
      end
      if (pop_en) begin
        free[top_var]       <= 1'b1;
        assignment[top_var] <= 1'b0;
        trail_count         <= LVL_W'(trail_count - LVL_W'(1));
      end
      if (lvl_inc) level <= LVL_W'(level + LVL_W'(1));
      if (set_conflict) conflict <= 1'b1;
      if (bt_latch) bt_target <= bt_level;
      if (bt_finish) begin
        conflict <= 1'b0;
        level    <= (bt_target < level) ? bt_target : level;
      end
    end
  end

  // Trail storage; contents are don't-care after reset
  always_ff @(posedge clock) begin
    if (push_en) begin
      trail_var[push_idx] <= push_var;
      trail_lvl[push_idx] <= push_lvl;
    end
  end

`ifdef BCP_TRAIL_STATS_EN
  logic [15:0] conf_cnt, imp_cnt;

  // Saturating event counters for conflicts and implication pushes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conf_cnt <= '0;
      imp_cnt  <= '0;
    end else begin
      if (set_conflict && (conf_cnt != 16'hFFFF)) conf_cnt <= conf_cnt + 16'd1;
      if (push_en && (state == S_WAIT) && (imp_cnt != 16'hFFFF)) imp_cnt <= imp_cnt + 16'd1;
    end
  end

  assign stat_conflicts = conf_cnt;
  assign stat_imps      = imp_cnt;
`else
  assign stat_conflicts = 16'd0;
  assign stat_imps      = 16'd0;
`endif

endmodule

// File: tb/tb_bcp_assign_trail.sv
// Self-checking bench for bcp_assign_trail: a small behavioural model produces
// expected snapshots into a scoreboard queue; tasks pop and compare after the DUT responds.
module tb_bcp_assign_trail;

  logic       clock = 1'b0;
  logic       reset;
  logic       dec_valid, dec_ready, dec_val;
  logic [2:0] dec_var;
  logic       bt_valid;
  logic [3:0] bt_level;
  logic       chk_request, chk_done, chk_conflict, chk_imp_valid, chk_imp_val;
  logic [2:0] chk_imp_var;
  logic [7:0] free, assignment;
  logic [3:0] level, trail_count;
  logic       conflict, all_assigned, dec_err;
  logic [15:0] stat_conflicts, stat_imps;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [7:0] m_free;
  logic [7:0] m_asg;
  int         m_level;
  logic       m_conf;
  int         mt_var[$];
  int         mt_lvl[$];
  int         m_nconf, m_nimp;
  logic [24:0] sb[$];

  bcp_assign_trail dut (
    .clock(clock), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_var(dec_var), .dec_val(dec_val),
    .bt_valid(bt_valid), .bt_level(bt_level),
    .chk_request(chk_request), .chk_done(chk_done), .chk_conflict(chk_conflict),
    .chk_imp_valid(chk_imp_valid), .chk_imp_var(chk_imp_var), .chk_imp_val(chk_imp_val),
    .free(free), .assignment(assignment), .level(level), .trail_count(trail_count),
    .conflict(conflict), .all_assigned(all_assigned), .dec_err(dec_err),
    .stat_conflicts(stat_conflicts), .stat_imps(stat_imps)
  );

  always #5 clock = ~clock;

  function automatic logic [24:0] dut_snap();
    return {free, assignment, level, trail_count, conflict};
  endfunction

  function automatic logic [24:0] m_snap();
    return {m_free, m_asg, 4'(m_level), 4'(mt_var.size()), m_conf};
  endfunction

  function automatic void m_reset();
    m_free = 8'hFF; m_asg = 8'h00; m_level = 0; m_conf = 1'b0;
    mt_var.delete(); mt_lvl.delete(); m_nconf = 0; m_nimp = 0;
  endfunction

  function automatic void m_push(input int v, input logic b, input int l);
    mt_var.push_back(v); mt_lvl.push_back(l);
    m_free[v] = 1'b0; m_asg[v] = b;
  endfunction

  function automatic int m_bt(input int t);
    int pops = 0;
    while (mt_var.size() > 0 && mt_lvl[mt_lvl.size()-1] > t) begin
      m_free[mt_var[mt_var.size()-1]] = 1'b1;
      m_asg[mt_var[mt_var.size()-1]]  = 1'b0;
      void'(mt_var.pop_back()); void'(mt_lvl.pop_back());
      pops++;
    end
    if (t < m_level) m_level = t;
    m_conf = 1'b0;
    return pops;
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic decide(input int v, input logic b);
    dec_valid = 1'b1; dec_var = 3'(v); dec_val = b;
    tick();
    dec_valid = 1'b0;
  endtask

  task automatic respond(input logic c, input logic iv, input int v, input logic b);
    chk_done = 1'b1; chk_conflict = c; chk_imp_valid = iv; chk_imp_var = 3'(v); chk_imp_val = b;
    tick();
    chk_done = 1'b0; chk_conflict = 1'b0; chk_imp_valid = 1'b0;
  endtask

  // Cycles until chk_request is seen (-1 on timeout); leaves the DUT in WAIT
  task automatic wait_req(output int n);
    n = -1;
    for (int i = 0; i < 10; i++) begin
      if (chk_request === 1'b1) begin
        n = i;
        tick();
        return;
      end
      tick();
    end
  endtask

  // Backtrack; returns cycles from the command edge until conflict clears / IDLE (-1 on timeout)
  task automatic bt(input int t, output int n);
    bt_valid = 1'b1; bt_level = 4'(t);
    tick();
    bt_valid = 1'b0;
    n = -1;
    for (int i = 1; i < 20; i++) begin
      tick();
      if (dec_ready === 1'b1 || all_assigned === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic [24:0] got, exp;
    reset = 1'b0;
    dec_valid = 0; dec_var = 0; dec_val = 0; bt_valid = 0; bt_level = 0;
    chk_done = 0; chk_conflict = 0; chk_imp_valid = 0; chk_imp_var = 0; chk_imp_val = 0;
    m_reset();
    sb.push_back(m_snap());
    repeat (2) tick();
    reset = 1'b1;
    tick();
    got = dut_snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_snap got %h exp %h", got, exp); end
    checks++;
    if ({chk_request, dec_err, dec_ready} !== 3'b001) begin
      errors++; $display("FAIL reset_ctrl got %b exp 001", {chk_request, dec_err, dec_ready});
    end
    checks++;
    if ({stat_conflicts, stat_imps} !== 32'd0) begin
      errors++; $display("FAIL reset_stats got %h exp 0", {stat_conflicts, stat_imps});
    end
  endtask

  task automatic test_decide_imp();
    logic [24:0] got, exp;
    int n;
    m_level++; m_push(3, 1'b1, m_level); sb.push_back(m_snap());
    decide(3, 1'b1);
    got = dut_snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL decide3 got %h exp %h", got, exp); end
    wait_req(n); checks++;
    if (n !== 0) begin errors++; $display("FAIL req_latency got %0d exp 0", n); end
    checks++;
    if (chk_request !== 1'b0) begin errors++; $display("FAIL req_one_cycle got %b exp 0", chk_request); end
    m_push(5, 1'b0, m_level); m_nimp++; sb.push_back(m_snap());
    respond(1'b0, 1'b1, 5, 1'b0);
    got = dut_snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL imp5 got %h exp %h", got, exp); end
    wait_req(n); checks++;
    if (n !== 0) begin errors++; $display("FAIL reprop_latency got %0d exp 0", n); end
    respond(1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (dec_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", dec_ready); end
  endtask

  task automatic test_conflict();
    logic [24:0] got, exp;
    int n, pops;
    m_level++; m_push(6, 1'b0, m_level);
    decide(6, 1'b0);
    wait_req(n);
    m_conf = 1'b1; m_nconf++; sb.push_back(m_snap());
    respond(1'b1, 1'b1, 0, 1'b1);
    got = dut_snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL conflict_snap got %h exp %h", got, exp); end
    checks++;
    if (dec_ready !== 1'b0) begin errors++; $display("FAIL conflict_ready got %b exp 0", dec_ready); end
    sb.push_back(m_snap());
    decide(0, 1'b1);
    got = dut_snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL conflict_ignore_dec got %h exp %h", got, exp); end
    pops = m_bt(0); sb.push_back(m_snap());
    bt(0, n);
    checks++;
    if (n !== pops + 1) begin errors++; $display("FAIL bt0_latency got %0d exp %0d", n, pops + 1); end
    got = dut_snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bt0_snap got %h exp %h", got, exp); end
  endtask

  task automatic test_polarity();
    logic [24:0] got, exp;
    int n, pops;
    m_level++; m_push(2, 1'b1, m_level);
    decide(2, 1'b1);
    wait_req(n);
    sb.push_back(m_snap());
    respond(1'b0, 1'b1, 2, 1'b1);
    got = dut_snap(); exp = sb.pop_front(); checks++;
    if (got !== exp || dec_ready !== 1'b1) begin
      errors++; $display("FAIL same_pol got %h/%b exp %h/1", got, dec_ready, exp);
    end
    m_level++; m_push(4, 1'b0, m_level);
    decide(4, 1'b0);
    wait_req(n);
    m_conf = 1'b1; m_nconf++; sb.push_back(m_snap());
    respond(1'b0, 1'b1, 2, 1'b0);
    got = dut_snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL opp_pol got %h exp %h", got, exp); end
    pops = m_bt(0);
    bt(0, n);
    checks++;
    if (n !== pops + 1) begin errors++; $display("FAIL opp_bt_latency got %0d exp %0d", n, pops + 1); end
  endtask

  task automatic test_selective_bt();
    logic [24:0] got, exp;
    int n, pops;
    m_level++; m_push(1, 1'b1, m_level);
    decide(1, 1'b1); wait_req(n); respond(1'b0, 1'b0, 0, 1'b0);
    m_level++; m_push(2, 1'b0, m_level);
    decide(2, 1'b0); wait_req(n);
    m_push(7, 1'b1, m_level); m_nimp++;
    respond(1'b0, 1'b1, 7, 1'b1); wait_req(n); respond(1'b0, 1'b0, 0, 1'b0);
    m_level++; m_push(5, 1'b1, m_level);
    decide(5, 1'b1); wait_req(n);
    sb.push_back(m_snap());
    respond(1'b0, 1'b0, 0, 1'b0);
    got = dut_snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL sel_build got %h exp %h", got, exp); end
    pops = m_bt(1); sb.push_back(m_snap());
    bt(1, n);
    checks++;
    if (n !== pops + 1) begin errors++; $display("FAIL sel_latency got %0d exp %0d", n, pops + 1); end
    got = dut_snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL sel_snap got %h exp %h", got, exp); end
  endtask

  task automatic test_dec_err();
    logic [24:0] got, exp;
    sb.push_back(m_snap());
    decide(1, 1'b0);
    got = dut_snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL dec_err_snap got %h exp %h", got, exp); end
    checks++;
    if ({dec_err, chk_request} !== 2'b10) begin
      errors++; $display("FAIL dec_err_pulse got %b exp 10", {dec_err, chk_request});
    end
    tick();
    checks++;
    if (dec_err !== 1'b0) begin errors++; $display("FAIL dec_err_clear got %b exp 0", dec_err); end
  endtask

  task automatic test_all_assigned();
    logic [24:0] got, exp;
    int n;
    void'(m_bt(0));
    bt(0, n);
    for (int v = 0; v < 8; v++) begin
      m_level++; m_push(v, 1'(v), m_level);
      decide(v, 1'(v)); wait_req(n); respond(1'b0, 1'b0, 0, 1'b0);
    end
    sb.push_back(m_snap());
    got = dut_snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL full_snap got %h exp %h", got, exp); end
    checks++;
    if ({all_assigned, dec_ready} !== 2'b10) begin
      errors++; $display("FAIL full_flags got %b exp 10", {all_assigned, dec_ready});
    end
  endtask

  task automatic test_stats();
    logic [15:0] ec, ei;
`ifdef BCP_TRAIL_STATS_EN
    ec = 16'(m_nconf); ei = 16'(m_nimp);
`else
    ec = 16'd0; ei = 16'd0;
`endif
    checks++;
    if ({stat_conflicts, stat_imps} !== {ec, ei}) begin
      errors++; $display("FAIL stats got %0d/%0d exp %0d/%0d", stat_conflicts, stat_imps, ec, ei);
    end
  endtask

  task automatic test_reset_in_bt();
    logic [24:0] got, exp;
    bt_valid = 1'b1; bt_level = 4'd0;
    tick();
    bt_valid = 1'b0;
    tick();
    #2 reset = 1'b0;
    m_reset(); sb.push_back(m_snap());
    #1;
    got = dut_snap(); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL rst_bt_snap got %h exp %h", got, exp); end
    checks++;
    if ({chk_request, dec_err, stat_conflicts, stat_imps} !== 34'd0) begin
      errors++; $display("FAIL rst_bt_ctrl got %h exp 0", {chk_request, dec_err, stat_conflicts, stat_imps});
    end
    tick();
    reset = 1'b1;
    tick();
    sb.push_back(m_snap());
    respond(1'b0, 1'b1, 0, 1'b1);
    got = dut_snap(); exp = sb.pop_front(); checks++;
    if (got !== exp || dec_ready !== 1'b1 || chk_request !== 1'b0) begin
      errors++; $display("FAIL stale_done got %h/%b exp %h/1", got, dec_ready, exp);
    end
  endtask

  initial begin
    test_reset();
    test_decide_imp();
    test_conflict();
    test_polarity();
    test_selective_bt();
    test_dec_err();
    test_all_assigned();
    test_stats();
    test_reset_in_bt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
